// File: rtl/secuenciador_barrido.sv
// Scan sequencer for a downstream 2-to-4 decoder: walks the enabled outputs in
// a latched mask, dwelling divisor+1 cycles on each, with optional blanking.
module secuenciador_barrido #(
  parameter int ANCHO_DIV = 8,
  parameter int BLANCO    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 modo,
  input  logic [3:0]           mascara,
  input  logic [ANCHO_DIV-1:0] divisor,
  output logic                 a0,
  output logic                 a1,
  output logic                 en,
  output logic                 ocupado,
  output logic                 fin
);

  typedef enum logic [1:0] {REPOSO, ACTIVO, ESPERA} estado_t;

  localparam logic [3:0] BLK_INI = (BLANCO > 0) ? 4'(BLANCO - 1) : 4'd0;

  estado_t              estado_q, estado_d;
  logic [1:0]           idx_q, idx_d;
  logic [ANCHO_DIV-1:0] cnt_q, cnt_d;
  logic [ANCHO_DIV-1:0] div_q, div_d;
  logic [3:0]           blk_q, blk_d;
  logic [3:0]           masc_q, masc_d;
  logic                 modo_q, modo_d;
  logic                 en_q, en_d;
  logic                 fin_q, fin_d;

  logic [1:0] sig_idx, cand, primero;
  logic       hallado, vuelta;

  // Next enabled index above the current one, wrapping; a lone bit maps to itself.
  always_comb begin
    sig_idx = idx_q;
    hallado = 1'b0;
    cand    = idx_q;
    for (int k = 1; k < 4; k++) begin
      cand = idx_q + 2'(k);
      if (!hallado && masc_q[cand]) begin
        sig_idx = cand;
        hallado = 1'b1;
      end
    end
    vuelta = (sig_idx <= idx_q);
  end

  always_comb begin
    if (mascara[0])      primero = 2'd0;
    else if (mascara[1]) primero = 2'd1;
    else if (mascara[2]) primero = 2'd2;
    else                 primero = 2'd3;
  end

  always_comb begin
    estado_d = estado_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    blk_d    = blk_q;
    masc_d   = masc_q;
    modo_d   = modo_q;
    en_d     = en_q;
    fin_d    = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (start && !stop) begin
          masc_d = mascara;
          modo_d = modo;
          div_d  = divisor;
          if (mascara != 4'd0) begin
            estado_d = ACTIVO;
            idx_d    = primero;
            cnt_d    = divisor;
            en_d     = 1'b1;
          end else begin
            fin_d = 1'b1;
          end
        end
      end
      ACTIVO: begin
        if (stop) begin
          estado_d = REPOSO;
          idx_d    = 2'd0;
          cnt_d    = '0;
          en_d     = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (modo_q && vuelta) begin
          // Single pass ends on the wrap itself; no trailing blanking.
          estado_d = REPOSO;
          idx_d    = 2'd0;
          en_d     = 1'b0;
          fin_d    = 1'b1;
        end else if (BLANCO > 0) begin
          estado_d = ESPERA;
          blk_d    = BLK_INI;
          en_d     = 1'b0;
        end else begin
          idx_d = sig_idx;
          cnt_d = div_q;
        end
      end
      ESPERA: begin
        if (stop) begin
          estado_d = REPOSO;
          idx_d    = 2'd0;
          cnt_d    = '0;
          blk_d    = 4'd0;
          en_d     = 1'b0;
        end else if (blk_q != 4'd0) begin
          blk_d = blk_q - 1'b1;
        end else begin
          estado_d = ACTIVO;
          idx_d    = sig_idx;
          cnt_d    = div_q;
          en_d     = 1'b1;
        end
      end
      default: begin
        estado_d = REPOSO;
        idx_d    = 2'd0;
        en_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= REPOSO;
      idx_q    <= 2'd0;
      cnt_q    <= '0;
      div_q    <= '0;
      blk_q    <= 4'd0;
      masc_q   <= 4'd0;
      modo_q   <= 1'b0;
      en_q     <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      blk_q    <= blk_d;
      masc_q   <= masc_d;
      modo_q   <= modo_d;
      en_q     <= en_d;
      fin_q    <= fin_d;
    end
  end

  assign a0      = idx_q[0];
  assign a1      = idx_q[1];
  assign en      = en_q;
  assign ocupado = (estado_q != REPOSO);
  assign fin     = fin_q;

endmodule

// File: doc/secuenciador_barrido.md
SECUENCIADOR_BARRIDO -- requirements
Module: secuenciador_barrido

Interface
REQ-001 Parameter ANCHO_DIV, default 8, SHALL set the width of divisor and of the internal dwell counter.
REQ-002 Parameter BLANCO, default 1, SHALL set the blanking cycles between outputs; 0 means no blanking; legal range 0..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 start  input  1  begins a scan when idle.
REQ-006 stop  input  1  aborts any scan in progress.
REQ-007 modo  input  1  0 = continuous scan, 1 = single pass.
REQ-008 mascara  input  4  bit i = 1 enables output i (i = {a1,a0}).
REQ-009 divisor  input  ANCHO_DIV  dwell per output = divisor+1 cycles.
REQ-010 a0, a1  output  1 each  registered select code for the downstream 2-to-4 decoder.
REQ-011 en  output  1  registered decoder enable.
REQ-012 ocupado  output  1  high while not in REPOSO.
REQ-013 fin  output  1  one-cycle pulse at completion of a single pass.

Function
REQ-014 The block SHALL implement three states: REPOSO, ACTIVO and ESPERA (blanking).
REQ-015 In REPOSO: en=0, {a1,a0}=00, ocupado=0.
REQ-016 start=1 in REPOSO SHALL latch modo, mascara and divisor; input changes after that edge have no effect until the next start.
REQ-017 After a start with mascara≠0, the next edge SHALL enter ACTIVO with {a1,a0} = lowest set index of mascara and en=1.
REQ-018 After a start with mascara=0, the block SHALL stay in REPOSO and pulse fin for one cycle.
REQ-019 ACTIVO SHALL hold en=1 and the current index for exactly divisor+1 cycles; divisor=0 gives 1 cycle.
REQ-020 At dwell expiry with BLANCO>0, the block SHALL enter ESPERA for BLANCO cycles: en=0, {a1,a0} held at the current index.
REQ-021 At dwell expiry with BLANCO=0, the block SHALL go directly to the next index with en continuously 1.
REQ-022 The next index is the next set bit of the latched mascara above the current index, wrapping 3→0.
REQ-023 A wrap is a next index less than or equal to the current index; a single enabled bit always wraps.
REQ-024 modo=1, on wrap: the block SHALL enter REPOSO instead of selecting the next index, pulse fin on that same cycle, and skip the trailing ESPERA.
REQ-025 modo=0, on wrap: the block SHALL continue indefinitely.
REQ-026 stop=1 in ACTIVO or ESPERA SHALL enter REPOSO on the next edge with en=0, {a1,a0}=00, and no fin pulse.
REQ-027 stop has priority over start and over dwell expiry on the same edge.
REQ-028 start while ocupado=1 SHALL be ignored.
REQ-029 stop and start together in REPOSO: remain in REPOSO.
REQ-030 The dwell counter SHALL reload to divisor on every index change and count down to 0 without overflow.
REQ-031 en=1 SHALL only ever coincide with an index whose latched mascara bit is 1.

Reset
REQ-032 rst=1 SHALL force REPOSO immediately, independent of clk: en=0, a0=0, a1=0, ocupado=0, fin=0, counters 0, latched registers 0.
REQ-033 Reset asserted mid-scan SHALL abort with no fin pulse; the first start after release SHALL behave as from power-up.

Verification
REQ-034 Continuous scan, BLANCO=1: mascara=1111, divisor=2, modo=0, start pulse -> {a1,a0}=00,01,10,11,00… each with en=1 for 3 cycles, then 1 cycle en=0; ocupado=1 throughout.
REQ-035 Single pass with skipped outputs: mascara=1010, divisor=0, modo=1, BLANCO=0 -> en=1 on index 01 for 1 cycle, then index 11 for 1 cycle, then REPOSO with fin=1 for 1 cycle and ocupado=0.
REQ-036 Mid-scan abort: stop during the 2nd ACTIVO cycle of index 10 -> next edge en=0, {a1,a0}=00, ocupado=0, fin stays 0.
REQ-037 Latched inputs and busy start: change mascara 1111→0001 and pulse start while busy -> scan continues with 1111; mascara=0000 start from idle -> fin pulse, ocupado stays 0.
REQ-038 Asynchronous reset: rst asserted between clock edges during ACTIVO -> en and a0/a1 go to 0 before the next edge; a start after release restarts at the lowest enabled index.
REQ-039 Single enabled output: mascara=0100, modo=1, divisor=3 -> {a1,a0}=10 with en=1 for 4 cycles, then fin pulse.
